// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - fp16 field widths, align FSM states and operand field helpers
package fp16_pkg;

    localparam int EXP_W         = 5;
    localparam int FRAC_W        = 10;
    localparam int MANT_W        = 11;
    localparam int SHIFT_CAP_DEF = 13;

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        SHIFT,
        DONE
    } state_t;

    // Denormals share the exponent of the smallest normal binade.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [EXP_W+FRAC_W-1:0] x);
        return {(x[EXP_W+FRAC_W-1:FRAC_W] != '0), x[FRAC_W-1:0]};
    endfunction

endpackage

// File: rtl/exp_sub5.sv
// rtl/exp_sub5.sv - 5-bit carry-lookahead subtractor, diff = x + ~y + 1
module exp_sub5 (
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic [4:0] diff,
    output logic       borrow
);

    logic [4:0] p;
    logic [4:0] g;
    logic [5:0] c;

    always_comb begin
        p = x ^ ~y;
        g = x & ~y;
        c[0] = 1'b1;
        c[1] = g[0] | p[0];
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0]);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0]);
        diff   = p ^ c[4:0];
        // No carry out of x + ~y + 1 means y > x.
        borrow = ~c[5];
    end

endmodule

// File: rtl/exp_align_shifter.sv
// rtl/exp_align_shifter.sv - fp16 exponent compare and serial mantissa alignment shifter
module exp_align_shifter
    import fp16_pkg::*;
#(
    parameter int SHIFT_CAP = SHIFT_CAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  exp_big,
    output logic [4:0]  exp_diff,
    output logic [10:0] mant_big,
    output logic [10:0] mant_small,
    output logic [2:0]  grs,
    output logic        swapped
);

    localparam logic [EXP_W-1:0] CAP = EXP_W'(SHIFT_CAP);

    state_t             state;
    state_t             state_nxt;
    logic [14:0]        a_q;
    logic [14:0]        b_q;
    logic [EXP_W-1:0]   ea;
    logic [EXP_W-1:0]   eb;
    logic [EXP_W-1:0]   d_ab;
    logic [EXP_W-1:0]   d_ba;
    logic               bor_ab;
    logic               bor_ba;
    logic               b_big;
    logic [EXP_W-1:0]   diff_sel;
    logic [EXP_W-1:0]   cnt;
    logic [EXP_W-1:0]   cnt_init;
    logic               unused_sign;

    assign unused_sign = a[15] ^ b[15];

    exp_sub5 u_sub_ab (
        .x      (ea),
        .y      (eb),
        .diff   (d_ab),
        .borrow (bor_ab)
    );

    exp_sub5 u_sub_ba (
        .x      (eb),
        .y      (ea),
        .diff   (d_ba),
        .borrow (bor_ba)
    );

    always_comb begin
        ea       = eff_exp(a_q[14:10]);
        eb       = eff_exp(b_q[14:10]);
        // Equal exponents borrow in neither direction, so a stays the big operand.
        b_big    = bor_ab & ~bor_ba;
        diff_sel = b_big ? d_ba : d_ab;
        cnt_init = (diff_sel > CAP) ? CAP : diff_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_nxt = DIFF;
                end
            end
            DIFF: begin
                state_nxt = (cnt_init == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (cnt == EXP_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            exp_big    <= '0;
            exp_diff   <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            grs        <= '0;
            swapped    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a[14:0];
                        b_q <= b[14:0];
                    end
                end
                DIFF: begin
                    exp_big    <= b_big ? eb : ea;
                    exp_diff   <= diff_sel;
                    mant_big   <= b_big ? mant_of(b_q) : mant_of(a_q);
                    mant_small <= b_big ? mant_of(a_q) : mant_of(b_q);
                    grs        <= '0;
                    swapped    <= b_big;
                    cnt        <= cnt_init;
                end
                SHIFT: begin
                    mant_small <= mant_small >> 1;
                    grs        <= {mant_small[0], grs[2], grs[1] | grs[0]};
                    cnt        <= cnt - EXP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_align_shifter.sv
// tb/tb_exp_align_shifter.sv - directed self-checking bench for exp_align_shifter
module tb_exp_align_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  exp_big;
    logic [4:0]  exp_diff;
    logic [10:0] mant_big;
    logic [10:0] mant_small;
    logic [2:0]  grs;
    logic        swapped;

    int errors = 0;
    int checks = 0;

    exp_align_shifter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_big    (exp_big),
        .exp_diff   (exp_diff),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .grs        (grs),
        .swapped    (swapped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency is the index of the first edge, counting the accept edge as 0, at which out_valid is sampled high.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input int lat_exp, input logic [4:0] e_big, input logic [4:0] e_diff,
                          input logic [10:0] m_big, input logic [10:0] m_small,
                          input logic [2:0] g, input logic sw);
        int lat;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq({tag, ".busy"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, ".exp_big"}, 32'(exp_big), 32'(e_big));
        check_eq({tag, ".exp_diff"}, 32'(exp_diff), 32'(e_diff));
        check_eq({tag, ".mant_big"}, 32'(mant_big), 32'(m_big));
        check_eq({tag, ".mant_small"}, 32'(mant_small), 32'(m_small));
        check_eq({tag, ".grs"}, 32'(grs), 32'(g));
        check_eq({tag, ".swapped"}, 32'(swapped), 32'(sw));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        check_eq("rst.in_ready", 32'(in_ready), 32'd0);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.exp_big", 32'(exp_big), 32'd0);
        check_eq("rst.mant_big", 32'(mant_big), 32'd0);
        check_eq("rst.grs", 32'(grs), 32'd0);
        rst = 1'b0;
        step();
        check_eq("rst.ready_after", 32'(in_ready), 32'd1);

        run_op("align",   16'h3C00, 16'h3800, 3,  5'd15, 5'd1,  11'h400, 11'h200, 3'b000, 1'b0);
        run_op("swap",    16'h3800, 16'h3C00, 3,  5'd15, 5'd1,  11'h400, 11'h200, 3'b000, 1'b1);
        run_op("equal",   16'h3C01, 16'h3C00, 2,  5'd15, 5'd0,  11'h401, 11'h400, 3'b000, 1'b0);
        run_op("clamp",   16'h7800, 16'h0001, 15, 5'd30, 5'd29, 11'h400, 11'h000, 3'b001, 1'b0);
        run_op("grs_all", 16'h4800, 16'h3BFF, 6,  5'd18, 5'd4,  11'h400, 11'h07F, 3'b111, 1'b0);
        run_op("denorm",  16'h0001, 16'h0400, 2,  5'd1,  5'd0,  11'h001, 11'h400, 3'b000, 1'b0);
        run_op("exp31",   16'h3C00, 16'h7C00, 15, 5'd31, 5'd16, 11'h400, 11'h000, 3'b001, 1'b1);

        a        = 16'h3C00;
        b        = 16'h3800;
        in_valid = 1'b1;
        step();
        a   = 16'h7800;
        b   = 16'h0001;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check_eq("bp.latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp.valid", 32'(out_valid), 32'd1);
            check_eq("bp.in_ready", 32'(in_ready), 32'd0);
            check_eq("bp.mant_small", 32'(mant_small), 32'h200);
            check_eq("bp.exp_diff", 32'(exp_diff), 32'd1);
            check_eq("bp.exp_big", 32'(exp_big), 32'd15);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("bp.release_valid", 32'(out_valid), 32'd0);
        check_eq("bp.release_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("bp.no_second", 32'(out_valid), 32'd0);

        a        = 16'h7800;
        b        = 16'h0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("rstmid.not_done", 32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        check_eq("rstmid.valid", 32'(out_valid), 32'd0);
        check_eq("rstmid.in_ready", 32'(in_ready), 32'd0);
        check_eq("rstmid.exp_big", 32'(exp_big), 32'd0);
        check_eq("rstmid.exp_diff", 32'(exp_diff), 32'd0);
        check_eq("rstmid.mant_big", 32'(mant_big), 32'd0);
        check_eq("rstmid.mant_small", 32'(mant_small), 32'd0);
        check_eq("rstmid.grs", 32'(grs), 32'd0);
        check_eq("rstmid.swapped", 32'(swapped), 32'd0);
        rst = 1'b0;
        step();
        check_eq("rstmid.ready_after", 32'(in_ready), 32'd1);
        check_eq("rstmid.valid_after", 32'(out_valid), 32'd0);

        run_op("post_rst", 16'h3800, 16'h3C00, 3, 5'd15, 5'd1, 11'h400, 11'h200, 3'b000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_align_shifter.md
EXP_ALIGN_SHIFTER -- requirements
Module: exp_align_shifter

Interface
REQ-001 SHALL have parameter SHIFT_CAP, default 13, giving the maximum right-shift count; larger exponent differences clamp to it.
REQ-002 SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, in, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, in, 1, operand pair valid.
REQ-005 SHALL have port in_ready, out, 1, block accepts operands.
REQ-006 SHALL have ports a and b, in, 16 each, fp16 operands: sign[15], exp[14:10], frac[9:0].
REQ-007 SHALL have port out_valid, out, 1, result valid.
REQ-008 SHALL have port out_ready, in, 1, downstream accepts the result.
REQ-009 SHALL have port exp_big, out, 5, effective exponent of the larger-exponent operand.
REQ-010 SHALL have port exp_diff, out, 5, unclamped effective-exponent difference (big minus small).
REQ-011 SHALL have port mant_big, out, 11, hidden bit plus fraction of the larger operand, unshifted.
REQ-012 SHALL have port mant_small, out, 11, aligned mantissa of the smaller operand.
REQ-013 SHALL have port grs, out, 3, guard/round/sticky bits of the aligned mantissa.
REQ-014 SHALL have port swapped, out, 1, set when b was the larger-exponent operand.

Function
REQ-015 SHALL use effective exponent = max(exp,1) and hidden bit = (exp!=0); exp=31 is treated numerically, with no special-case handling.
REQ-016 SHALL use FSM states IDLE, DIFF, SHIFT and DONE.
REQ-017 IDLE: in_ready=1; in_valid&in_ready at edge k registers the operands and moves to DIFF.
REQ-018 DIFF, one cycle: computes both differences via subtractors, sets swapped=(eb>ea) and registers big/small; equal exponents give swapped=0.
REQ-019 From DIFF: shift count = min(diff,SHIFT_CAP); count 0 goes to DONE, otherwise to SHIFT.
REQ-020 SHIFT: each cycle shifts {mant_small,G,R,S} right one bit.
REQ-021 Shift bit rules: new G=mant_small[0], new R=old G, new S=old R|old S.
REQ-022 SHIFT: the counter decrements each cycle; at 1 the state moves to DONE.
REQ-023 DONE: out_valid=1 and all outputs held stable until out_valid&out_ready, then IDLE.
REQ-024 Latency: out_valid is first high min(diff,SHIFT_CAP)+2 cycles after the accept edge.
REQ-025 Throughput: one operation in flight; in_ready=0 in DIFF, SHIFT and DONE, and in_valid is ignored there.
REQ-026 Boundary: out_ready held low keeps DONE indefinitely with no output change.
REQ-027 Boundary: the cycle after the handshake returns to IDLE; a new accept is possible no earlier than that cycle.
REQ-028 Sign bits are not used or output.

Reset
REQ-029 rst high at an edge SHALL force IDLE from any state, including mid-SHIFT, and abort the operation.
REQ-030 Reset SHALL clear every output: out_valid=0, exp_big=0, exp_diff=0, mant_big=0, mant_small=0, grs=0, swapped=0.
REQ-031 in_ready SHALL be 0 while rst is high and 1 the cycle after rst falls.

Structure
REQ-032 Package fp16_pkg SHALL hold EXP_W=5, FRAC_W=10, MANT_W=11, the FSM state enum and the SHIFT_CAP default.
REQ-033 Sub-module exp_sub5 SHALL be a 5-bit carry-lookahead subtractor computing x+~y+1 with outputs diff[4:0] and borrow.
REQ-034 exp_sub5 SHALL be instantiated twice, for a-b and b-a, selected by borrow.

Verification
REQ-035 Alignment: a=0x3C00, b=0x3800 -> swapped=0, exp_big=15, exp_diff=1, mant_big=0x400, mant_small=0x200, grs=000, out_valid 3 cycles after accept.
REQ-036 Swap: a=0x3800, b=0x3C00 -> same as REQ-035 but swapped=1.
REQ-037 Equal exponents: a=0x3C01, b=0x3C00 -> swapped=0, exp_diff=0, mant_big=0x401, mant_small=0x400, grs=000, latency 2.
REQ-038 Clamp/denormal: a=0x7800, b=0x0001 -> exp_big=30, exp_diff=29, mant_small=0, grs=001, latency 15.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second accept; release -> one handshake, then IDLE.
REQ-040 Reset mid-op: assert rst during SHIFT of REQ-038 -> all outputs 0 next cycle, in_ready=1 the cycle after rst falls.
